// File: rtl/edge_pkg.sv
// rtl/edge_pkg.sv - shared state type and pixel width for the Sobel edge pipeline
package edge_pkg;

  typedef enum logic [1:0] {IDLE, ACCEPT, ISSUE, WAIT_DONE} state_t;

  localparam int PIXEL_W = 8;

endpackage

// File: rtl/sobel_line_buffer.sv
// rtl/sobel_line_buffer.sv - one image row of pixels, old value read while new value written
module sobel_line_buffer
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH = 16,
  parameter int COL_W     = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               we_i,
  input  logic [COL_W-1:0]   addr_i,
  input  logic [PIXEL_W-1:0] wdata_i,
  output logic [PIXEL_W-1:0] rdata_o
);

  logic [PIXEL_W-1:0] mem_q [IMG_WIDTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_feeder.sv
// rtl/sobel_window_feeder.sv - 3x3 window assembler feeding the Sobel gradient unit
// Optional window counter output enabled by SOBEL_WINDOW_STATS_EN.
module sobel_window_feeder
  import edge_pkg::*;
#(
  parameter int IMG_WIDTH = 16
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               i_pixel_valid,
  input  logic [PIXEL_W-1:0] i_pixel_data,
  input  logic               i_frame_start,
  output logic               o_pixel_ready,
  output logic               o_gradient_start,
  input  logic               i_gradient_data_ready,
  output logic [PIXEL_W-1:0] P0,
  output logic [PIXEL_W-1:0] P1,
  output logic [PIXEL_W-1:0] P2,
  output logic [PIXEL_W-1:0] P3,
  output logic [PIXEL_W-1:0] P4,
  output logic [PIXEL_W-1:0] P5,
  output logic [PIXEL_W-1:0] P6,
  output logic [PIXEL_W-1:0] P7,
  output logic [PIXEL_W-1:0] P8
`ifdef SOBEL_WINDOW_STATS_EN
  ,
  output logic [15:0]        o_window_count
`endif
);

  localparam int               COL_W    = $clog2(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d, col_eff;
  logic [1:0]         row_q, row_d, row_eff;
  logic [PIXEL_W-1:0] win_q [9];
  logic [PIXEL_W-1:0] win_d [9];
  logic [PIXEL_W-1:0] top_px, mid_px;
  logic               xfer, win_done;

  assign xfer     = i_pixel_valid && (state_q == ACCEPT);
  // A frame-start pixel is handled as column 0 of row 0 regardless of the counters.
  assign col_eff  = i_frame_start ? '0 : col_q;
  assign row_eff  = i_frame_start ? 2'd0 : row_q;
  assign win_done = xfer && (row_eff == 2'd2) && (col_eff >= COL_W'(2));

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .COL_W(COL_W)) lb1 (
    .clk     (clk),
    .we_i    (xfer),
    .addr_i  (col_eff),
    .wdata_i (i_pixel_data),
    .rdata_o (mid_px)
  );

  sobel_line_buffer #(.IMG_WIDTH(IMG_WIDTH), .COL_W(COL_W)) lb2 (
    .clk     (clk),
    .we_i    (xfer),
    .addr_i  (col_eff),
    .wdata_i (mid_px),
    .rdata_o (top_px)
  );

  always_comb begin
    state_d          = state_q;
    o_pixel_ready    = 1'b0;
    o_gradient_start = 1'b0;
    case (state_q)
      IDLE:      state_d = ACCEPT;
      ACCEPT: begin
        o_pixel_ready = 1'b1;
        if (win_done) state_d = ISSUE;
      end
      ISSUE: begin
        o_gradient_start = 1'b1;
        state_d          = WAIT_DONE;
      end
      WAIT_DONE: if (i_gradient_data_ready) state_d = ACCEPT;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (xfer) begin
      if (i_frame_start) begin
        col_d = COL_W'(1);
        row_d = 2'd0;
      end else if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q != 2'd2) row_d = row_q + 2'd1;
      end else begin
        col_d = col_q + COL_W'(1);
      end
      win_d[0] = win_q[1]; win_d[1] = win_q[2]; win_d[2] = top_px;
      win_d[3] = win_q[4]; win_d[4] = win_q[5]; win_d[5] = mid_px;
      win_d[6] = win_q[7]; win_d[7] = win_q[8]; win_d[8] = i_pixel_data;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
    end
  end

  assign P0 = win_q[0];
  assign P1 = win_q[1];
  assign P2 = win_q[2];
  assign P3 = win_q[3];
  assign P4 = win_q[4];
  assign P5 = win_q[5];
  assign P6 = win_q[6];
  assign P7 = win_q[7];
  assign P8 = win_q[8];

`ifdef SOBEL_WINDOW_STATS_EN
  logic [15:0] win_cnt_q, win_cnt_d;

  always_comb begin
    win_cnt_d = win_cnt_q;
    if (xfer && i_frame_start) win_cnt_d = '0;
    else if (win_done)         win_cnt_d = win_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) win_cnt_q <= '0;
    else        win_cnt_q <= win_cnt_d;
  end

  assign o_window_count = win_cnt_q;
`endif

endmodule

// File: doc/sobel_window_feeder.md
# sobel_window_feeder

Upstream stage of the Sobel gradient unit. It accepts a raster-ordered 8-bit pixel stream, keeps the two previous image rows in line buffers, and assembles each 3x3 neighbourhood into P0..P8. For every complete window it pulses `i_gradient_start` into the gradient unit, then holds the window stable and stalls the stream until that unit returns `o_gradient_data_ready`.

## Interface

- `IMG_WIDTH`, default 16: pixels per image row; legal range is 3 or more.
- `clk  in  1`: single clock, rising edge.
- `n_rst  in  1`: asynchronous, active-low reset.
- `i_pixel_valid  in  1`: the pixel on `i_pixel_data` is offered.
- `i_pixel_data  in  8`: unsigned pixel value.
- `i_frame_start  in  1`: qualifies the offered pixel as row 0, col 0 of a new frame.
- `o_pixel_ready  out  1`: feeder accepts the pixel this cycle; transfer occurs when valid and ready are both high.
- `o_gradient_start  out  1`: one-cycle pulse to the gradient unit.
- `i_gradient_data_ready  in  1`: done pulse from the gradient unit.
- `P0..P8  out  8 each`: window. P0–P2 are the top (oldest) row, P3–P5 the middle row, P6–P8 the bottom (newest) row; left to right within each row.

## Operation

- State machine (`state_t`):
  - IDLE → ACCEPT unconditionally.
  - ACCEPT → ISSUE on a transfer that completes a window; otherwise stay in ACCEPT.
  - ISSUE → WAIT_DONE unconditionally.
  - WAIT_DONE → ACCEPT when `i_gradient_data_ready`=1.
- Outputs decoded from state:
  - `o_pixel_ready` = (state==ACCEPT).
  - `o_gradient_start` = (state==ISSUE).
- Counters: `col` is 0..IMG_WIDTH-1; `row` is a 2-bit counter that saturates at 2.
- On each transfer at column c:
  - Read the column vector {top=lb2[c], mid=lb1[c], bot=pixel}.
  - Write lb2[c]←lb1[c] and lb1[c]←pixel.
  - Shift the window left: P0←P1←P2←top, P3←P4←P5←mid, P6←P7←P8←bot.
- Window complete: the transfer occurs with row==2 and col≥2, evaluated before the counters advance.
- Counter advance:
  - col==IMG_WIDTH-1 wraps col to 0 and increments `row` (saturating).
  - Otherwise col increments.
- `i_frame_start` on a transfer: the pixel is treated as col=0, row=0. Counters become col=1, row=0. Line buffer contents are not cleared; the row gate masks stale data.
- `i_frame_start` or `i_pixel_valid` outside ACCEPT: no transfer occurs, so both are ignored. The source holds its pixel.
- `i_gradient_data_ready` outside WAIT_DONE: ignored.
- Windows never span rows, because issue requires col≥2 and the left columns are refilled first.
- Arithmetic: pixels are unsigned 8-bit and pass through unmodified. The feeder does no arithmetic on pixel data.

## Timing

- Reset values: state=IDLE, `o_pixel_ready`=0, `o_gradient_start`=0, P0..P8=0, col=0, row=0. Line buffers are not reset.
- `o_pixel_ready` rises in the first cycle after reset release.
- Latency: the transfer edge that completes a window updates P0..P8 and enters ISSUE. `o_gradient_start` is high for exactly the following cycle.
- P0..P8 are stable from that edge until the next transfer, so they are constant for the whole gradient computation.
- Minimum turnaround: the first cycle of ACCEPT follows the `i_gradient_data_ready` edge directly.
- Reset mid-operation (any state): return to IDLE with all reset values. The next frame begins at the next `i_frame_start` transfer, or behaves as row 0 if none is given.

## Configuration

- `SOBEL_WINDOW_STATS_EN` defined adds:
  - `o_window_count  out  16`: number of ISSUE entries since reset.
  - It resets to 0, clears to 0 on an `i_frame_start` transfer, and wraps at 65535→0.
- Macro undefined: the port and counter are absent. Behaviour is otherwise identical.

## Structure

- Shared package `edge_pkg` holds:
  - `state_t` enum {IDLE, ACCEPT, ISSUE, WAIT_DONE}.
  - `PIXEL_W`=8.
- Sub-module `sobel_line_buffer`:
  - IMG_WIDTH×8 storage with one address.
  - Same-cycle read of the old value and write of the new value.
  - Instantiated twice, as lb1 and lb2.

## Test plan

- **Reset:** assert `n_rst`=0 mid-stream → all outputs 0; `o_pixel_ready`=1 one cycle after release; no `o_gradient_start`.
- **First window:** IMG_WIDTH=4, pixels 1..12 with valid held high and `i_gradient_data_ready` returned 3 cycles after start →
  - First start after pixel 11 with P=1,2,3,5,6,7,9,10,11.
  - After pixel 12, P=2,3,4,6,7,8,10,11,12.
  - Exactly 2 starts in total.
- **Stall:** delay `i_gradient_data_ready` by 20 cycles while valid is held with pixel 12 → `o_pixel_ready`=0; P0..P8 unchanged; pixel 12 is accepted in the cycle after the done pulse.
- **Spurious done:** pulse `i_gradient_data_ready` during ACCEPT → no state change; a later window issues normally.
- **Mid-row frame restart:** `i_frame_start` on the 6th pixel with IMG_WIDTH=4 → no start until 11 pixels (counting from the restart pixel) have been transferred; that window is the pixel values at positions 1,2,3,5,6,7,9,10,11 counted from the restart pixel.
- **Stats (macro on):** 4 rows of width 4 → `o_window_count`=4; a subsequent `i_frame_start` transfer clears it to 0.
